// File: rtl/fsm_seq_pkg.sv
// Shared command encodings and control-state type for the debugger-stepped
// sequence FSM.
package fsm_seq_pkg;

  localparam logic [1:0] CMD_CLR  = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ctrl_t;

endpackage

// File: rtl/step_counter.sv
// Saturating up-counter with synchronous clear; counts enabled debugger steps.
module step_counter #(
  parameter int STEPW = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [STEPW-1:0] cnt_o
);

  logic [STEPW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i)                  cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_seq_core.sv
// DEPTH-state sequence counter advanced only on debugger-granted steps, with
// up/down/load/clear commands, wrap or saturate-to-HALT, and event pulses.
module fsm_seq_core
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = $clog2(DEPTH),
  parameter bit WRAP  = 1'b1,
  parameter int STEPW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [1:0]       x_in,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] z_out,
  output logic [WIDTH-1:0] current_state_debug,
  output logic             halted,
  output logic             tc,
  output logic             load_err,
  output logic [STEPW-1:0] step_count
);

  // Range checks are done one bit wider so DEPTH is always representable.
  localparam logic [WIDTH:0]   DEPTH_X = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(DEPTH - 1);

  ctrl_t            state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             lerr_q, lerr_d;
  logic             load_ok, cnt_bad;
  logic [WIDTH-1:0] load_cnt;

  assign load_ok  = {1'b0, load_val} < DEPTH_X;
  assign cnt_bad  = {1'b0, cnt_q} >= DEPTH_X;
  assign load_cnt = load_ok ? load_val : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    lerr_d  = 1'b0;
    if (clk_enable) begin
      case (state_q)
        RUN: begin
          case (x_in)
            CMD_CLR: cnt_d = '0;
            CMD_UP: begin
              if (cnt_q == MAXV) begin
                tc_d = 1'b1;
                if (WRAP) cnt_d = '0;
                else      state_d = HALT;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            CMD_DOWN: begin
              if (cnt_q == '0) begin
                tc_d = 1'b1;
                if (WRAP) cnt_d = MAXV;
                else      state_d = HALT;
              end else begin
                cnt_d = cnt_q - 1'b1;
              end
            end
            CMD_LOAD: begin
              cnt_d  = load_cnt;
              lerr_d = !load_ok;
            end
          endcase
        end
        HALT: begin
          // Only CLR/LOAD leave HALT; UP/DOWN hold the saturated count.
          if (x_in == CMD_CLR) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (x_in == CMD_LOAD) begin
            state_d = RUN;
            cnt_d   = load_cnt;
            lerr_d  = !load_ok;
          end
        end
        default: state_d = RUN;
      endcase
      if (cnt_bad) cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      lerr_q  <= lerr_d;
    end
  end

  step_counter #(.STEPW(STEPW)) u_step (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (clk_enable),
    .cnt_o (step_count)
  );

  assign z_out = (state_q == RUN && (x_in == CMD_UP || x_in == CMD_DOWN)) ? cnt_q : '0;
  assign current_state_debug = cnt_q;
  assign halted   = (state_q == HALT);
  assign tc       = tc_q;
  assign load_err = lerr_q;

endmodule
